// File: rtl/receiver_axis.sv
// UART receiver (start, WORD_WIDTH data bits LSB first, one stop bit)
// with an AXI4-Stream master output and one-cycle error pulses.
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   din               - asynchronous serial line, idle high
//   dout_axis_tdata   - received word
//   dout_axis_tvalid  - word available (registered)
//   dout_axis_tready  - consumer accepts the word
//   frame_error       - pulse when the stop bit is sampled low
//   overrun           - pulse when a good word is dropped (output busy)
module receiver_axis #(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200,
    parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    output logic [WORD_WIDTH-1:0] dout_axis_tdata,
    output logic                  dout_axis_tvalid,
    input  logic                  dout_axis_tready,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam int unsigned CPB  = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned IW   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q;
    logic [1:0]            sync_q;
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic [WORD_WIDTH-1:0] shreg_q;
    logic [WORD_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  ferr_q;
    logic                  ovr_q;
    logic                  din_s;
    logic                  out_free;

    // sync_q[0] is the first flop, sync_q[1] the synchronized line.
    assign din_s = sync_q[1];

    // A word may load when the slot is empty or drains this same cycle.
    assign out_free = !tvalid_q || dout_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // A load in STOP below overrides this clear.
            if (tvalid_q && dout_axis_tready) begin
                tvalid_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (!din_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= din_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        shreg_q[idx_q] <= din_s;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    // Leaving mid stop bit lets a back-to-back start
                    // bit be seen from its first cycle.
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (!din_s) begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end else begin
                            state_q <= S_IDLE;
                            if (out_free) begin
                                tdata_q  <= shreg_q;
                                tvalid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_BREAK: begin
                    // A held-low line must rise before a new frame.
                    if (din_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout_axis_tdata  = tdata_q;
    assign dout_axis_tvalid = tvalid_q;
    assign frame_error      = ferr_q;
    assign overrun          = ovr_q;

endmodule

// File: tb/tb_receiver_axis.sv
// Self-checking bench for receiver_axis.
// Scaled line rate: 20 clocks per bit, sample point after 10.
module tb_receiver_axis;

    localparam logic [31:0] CF = 32'd1_000_000;
    localparam logic [31:0] BR = 32'd50_000;
    localparam int CPB  = 20;
    localparam int HALF = 10;
    // Cycles from E to the stop-bit sampling edge.
    localparam int LAT  = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       tready;
    logic [7:0] tdata;
    logic       tvalid;
    logic       fe;
    logic       ov;

    receiver_axis #(
        .CLOCK_FREQUENCY(CF),
        .BAUD_RATE      (BR),
        .WORD_WIDTH     (32'd8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .din             (din),
        .dout_axis_tdata (tdata),
        .dout_axis_tvalid(tvalid),
        .dout_axis_tready(tready),
        .frame_error     (fe),
        .overrun         (ov)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a transfer seen mid-cycle completes on the next edge.
    logic [7:0] xd [64];
    int         xc [64];
    int         xn   = 0;
    int         fe_n = 0;
    int         fe_c = 0;
    int         ov_n = 0;
    int         ov_c = 0;

    always @(negedge clk) begin
        if (tvalid && tready && xn < 64) begin
            xd[xn] <= tdata;
            xc[xn] <= cyc;
            xn     <= xn + 1;
        end
        if (fe) begin
            fe_n <= fe_n + 1;
            fe_c <= cyc;
        end
        if (ov) begin
            ov_n <= ov_n + 1;
            ov_c <= cyc;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drives one frame; e returns the cycle index of edge E.
    task automatic send(input logic [7:0] d, input logic sb,
                        output int e);
        din = 1'b0;
        e   = cyc + 1;
        repeat (CPB) step();
        for (int k = 0; k < 8; k++) begin
            din = d[k];
            repeat (CPB) step();
        end
        din = sb;
        repeat (CPB) step();
        din = 1'b1;
    endtask

    // Frame cut by a one-cycle reset mid data bit k; line goes idle.
    task automatic send_abort(input logic [7:0] d, input int k);
        din = 1'b0;
        repeat (CPB) step();
        for (int j = 0; j < k; j++) begin
            din = d[j];
            repeat (CPB) step();
        end
        din = d[k];
        repeat (CPB / 2) step();
        rst = 1'b1;
        din = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       sb;
        int         low;
        logic       xv;
        logic       xf;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int x0, f0, o0, e, e2;

        tbl[0] = '{8'hA5, 1'b1, 0, 1'b1, 1'b0};
        tbl[1] = '{8'h55, 1'b0, 3, 1'b0, 1'b1};
        tbl[2] = '{8'h5A, 1'b1, 0, 1'b1, 1'b0};
        tbl[3] = '{8'h3C, 1'b1, 0, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 0, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 0, 1'b1, 1'b0};
        tbl[6] = '{8'h7E, 1'b0, 0, 1'b0, 1'b1};
        tbl[7] = '{8'h81, 1'b1, 0, 1'b1, 1'b0};

        rst    = 1'b1;
        din    = 1'b1;
        tready = 1'b1;
        repeat (3) step();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_fe", fe, 0);
        chk("rst_ov", ov, 0);
        rst = 1'b0;
        step();

        // Low glitch shorter than half a bit: a false start.
        x0 = xn; f0 = fe_n; o0 = ov_n;
        din = 1'b0;
        repeat (HALF - 4) step();
        din = 1'b1;
        repeat (3 * CPB) step();
        chk("glitch_xfer", xn - x0, 0);
        chk("glitch_fe", fe_n - f0, 0);
        chk("glitch_ov", ov_n - o0, 0);

        for (int i = 0; i < 8; i++) begin
            x0 = xn; f0 = fe_n; o0 = ov_n;
            send(tbl[i].d, tbl[i].sb, e);
            if (tbl[i].low > 0) begin
                din = 1'b0;
                repeat (tbl[i].low * CPB) step();
                din = 1'b1;
            end
            repeat (2 * CPB) step();
            chk($sformatf("v%0d_xfer", i), xn - x0, int'(tbl[i].xv));
            chk($sformatf("v%0d_fe", i), fe_n - f0, int'(tbl[i].xf));
            chk($sformatf("v%0d_ov", i), ov_n - o0, 0);
            chk($sformatf("v%0d_tvalid_low", i), tvalid, 0);
            if (tbl[i].xv) begin
                chk($sformatf("v%0d_data", i), xd[x0], tbl[i].d);
                chk($sformatf("v%0d_lat", i), xc[x0] - e, LAT);
            end
            if (tbl[i].xf) begin
                chk($sformatf("v%0d_fe_lat", i), fe_c - e, LAT);
            end
        end

        // Held output.
        tready = 1'b0;
        x0 = xn;
        send(8'h3C, 1'b1, e);
        repeat (3 * CPB) step();
        chk("held_tvalid", tvalid, 1);
        chk("held_tdata", tdata, 8'h3C);
        chk("held_noxfer", xn - x0, 0);
        tready = 1'b1;
        step();
        chk("held_xfer", xn - x0, 1);
        chk("held_xdata", xd[x0], 8'h3C);
        chk("held_clear", tvalid, 0);

        // Overrun: second word dropped, first kept.
        tready = 1'b0;
        x0 = xn; f0 = fe_n; o0 = ov_n;
        send(8'h11, 1'b1, e);
        send(8'h22, 1'b1, e2);
        repeat (2 * CPB) step();
        chk("ovr_cnt", ov_n - o0, 1);
        chk("ovr_lat", ov_c - e2, LAT);
        chk("ovr_fe", fe_n - f0, 0);
        chk("ovr_tvalid", tvalid, 1);
        chk("ovr_tdata", tdata, 8'h11);
        tready = 1'b1;
        repeat (CPB) step();
        chk("ovr_xfer", xn - x0, 1);
        chk("ovr_xdata", xd[x0], 8'h11);
        chk("ovr_clear", tvalid, 0);

        // Back-to-back streaming.
        x0 = xn; f0 = fe_n; o0 = ov_n;
        send(8'h00, 1'b1, e);
        send(8'hFF, 1'b1, e2);
        send(8'h81, 1'b1, e2);
        repeat (2 * CPB) step();
        chk("str_cnt", xn - x0, 3);
        chk("str_d0", xd[x0], 8'h00);
        chk("str_d1", xd[x0 + 1], 8'hFF);
        chk("str_d2", xd[x0 + 2], 8'h81);
        chk("str_lat", xc[x0] - e, LAT);
        chk("str_gap1", xc[x0 + 1] - xc[x0], 10 * CPB);
        chk("str_gap2", xc[x0 + 2] - xc[x0 + 1], 10 * CPB);
        chk("str_err", (fe_n - f0) + (ov_n - o0), 0);

        // Reset in data bit 4, then a clean frame.
        x0 = xn; f0 = fe_n; o0 = ov_n;
        send_abort(8'hA5, 4);
        repeat (12 * CPB) step();
        chk("rstmid_xfer", xn - x0, 0);
        chk("rstmid_tvalid", tvalid, 0);
        chk("rstmid_err", (fe_n - f0) + (ov_n - o0), 0);
        send(8'hC3, 1'b1, e);
        repeat (2 * CPB) step();
        chk("rstmid_next_xfer", xn - x0, 1);
        chk("rstmid_next_data", xd[x0], 8'hC3);
        chk("rstmid_next_lat", xc[x0] - e, LAT);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/receiver_axis.md
# receiver_axis

UART receiver with an AXI4-Stream master output. It is the receive-side companion of the team's UART transmitter. It oversamples the asynchronous serial line `din` with the system clock and recovers 8N1-style frames: start bit, WORD_WIDTH data bits LSB-first, one stop bit. Each good word is presented on `dout_axis_*`, and framing and overrun events are reported as single-cycle pulses.

## Interface
- `CLOCK_FREQUENCY`, default 32'd100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 32'd115200: line rate in bit/s.
- `WORD_WIDTH`, default 32'd8: data bits per frame.
- Derived: `CPB` = CLOCK_FREQUENCY/BAUD_RATE (integer division, 868 at defaults); `HALF` = CPB/2 (434).
- `clk` input, 1 bit: single system clock; all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `din` input, 1 bit: asynchronous serial line, idle high.
- `dout_axis_tdata` output, WORD_WIDTH bits: received word.
- `dout_axis_tvalid` output, 1 bit: word available.
- `dout_axis_tready` input, 1 bit: consumer accepts the word.
- `frame_error` output, 1 bit: one-cycle pulse when the stop bit is sampled 0.
- `overrun` output, 1 bit: one-cycle pulse when a completed word is dropped because the output is still occupied.

## Operation
- `din` passes through a 2-flop synchronizer. The synchronized value is `din_s`, and both flops reset to 1.
- The FSM has the states IDLE, START, DATA, STOP, BREAK. One counter `cnt` (clog2(CPB) bits) and one bit index `idx` are used.
- **IDLE**: when `din_s`==0, go to START with `cnt`=0.
- **START**: increment `cnt`. At `cnt`==HALF-1, sample `din_s`:
  - If it is 1 (false start), return to IDLE.
  - If it is 0, go to DATA with `cnt`=0 and `idx`=0.
- **DATA**: at `cnt`==CPB-1, shift `din_s` into bit `idx` (LSB first) and reset `cnt` to 0.
  - After bit WORD_WIDTH-1, go to STOP.
- **STOP**: at `cnt`==CPB-1, sample `din_s`:
  - If it is 1 and the output is free (tvalid==0, or tvalid&&tready in that same cycle), load tdata, set tvalid=1, and go to IDLE.
  - If it is 1 and the output is occupied, discard the word, pulse `overrun`, and go to IDLE. The held word and tvalid are unchanged.
  - If it is 0, discard the word, pulse `frame_error`, and go to BREAK.
- **BREAK**: wait until `din_s`==1, then go to IDLE. This stops a held-low line (break) from producing repeated frames.
- **Output register**:
  - tvalid&&tready clears tvalid, unless a new word loads in the same cycle; in that case tvalid stays 1 with the new tdata.
  - tdata is stable while tvalid=1 and tready=0.
  - tvalid never depends combinationally on tready.

## Timing
- **Reset values**: tdata=0, tvalid=0, frame_error=0, overrun=0, state IDLE, synchronizer flops=1.
- **Reset mid-frame**: the frame is abandoned and no output or pulse is produced. Reception resumes at the next falling edge after reset is released.
- **Latency**: let E be the first edge at which the first synchronizer flop captures `din`=0.
  - START is entered at edge E+2.
  - The start bit is sampled at E+2+HALF.
  - Data bit k is sampled at E+2+HALF+(k+1)·CPB.
  - The stop bit is sampled at E+2+HALF+(WORD_WIDTH+1)·CPB. tvalid is 1 after this edge; at defaults that is E+8248.
  - `frame_error` and `overrun` are high for exactly the one cycle after that same edge.
- **Back-to-back frames**: IDLE is re-entered mid-stop-bit, so a start bit immediately following the stop bit is received with no lost word.
- **Baud tolerance**: the mid-bit sampling point gives ±HALF cycles of accumulated drift over one frame.

## Test plan
- **Single word**: reset; tready=1; drive 0xA5 at 115200 baud (868 clocks/bit). Expect tvalid=1 with tdata=0xA5 exactly at E+8248, high for one cycle, no error pulses, tvalid=0 afterwards.
- **Held output**: tready=0; send 0x3C. Expect tvalid to stay 1 with tdata=0x3C until tready=1, then tvalid=0 on the following cycle.
- **Overrun**: tready=0; send 0x11 then 0x22 back-to-back. Expect one `overrun` pulse at the end of the second frame, tdata still 0x11. After tready=1, exactly one transfer of 0x11.
- **False start and framing error**:
  - A 200-cycle low glitch on `din` gives no tvalid, no pulses, and state IDLE.
  - A frame 0x55 with stop bit 0 and `din` held low 3 more bit times gives one `frame_error` pulse and no tvalid. A following valid 0x5A is received correctly.
- **Streaming**: tready=1; send 0x00, 0xFF, 0x81 with no idle gaps. Expect three transfers in order, spaced 10·CPB cycles apart.
- **Reset mid-frame**: assert rst for 1 cycle during data bit 4 of 0xA5. Expect no tvalid and no pulses for that frame; a subsequent 0xC3 is received correctly.
